// File: rtl/ps_mem_host_pkg.sv
// Shared types and defaults for the processor-side memory host.
package ps_mem_host_pkg;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_TIMEOUT      = 4096;
  localparam int DEF_DUMP_WORDS   = 2 ** DEF_ADDR_WIDTH;
  localparam int CNT_W            = 16;

  typedef enum logic [2:0] {
    LOAD, START, RUN, DRAIN, DUMP_RD, DUMP_OUT, DONE
  } state_t;
endpackage

// File: rtl/ps_mem_host_sram.sv
// Single-port synchronous RAM; a read returns the word held before any same-edge write.
module ps_sram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] r_data
);
  logic [DW-1:0] mem [2**AW];

  // Array has no reset so contents survive rst.
  always_ff @(posedge clk)
    if (wr) mem[addr] <= w_data;

  always_ff @(posedge clk or posedge rst)
    if (rst)     r_data <= '0;
    else if (rd) r_data <= mem[addr];
endmodule

// File: rtl/ps_mem_host.sv
// Host wrapper: loads IM/DM, starts the processor, watches for stop/timeout, then streams DM out.
module ps_mem_host
  import ps_mem_host_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int DUMP_WORDS   = DEF_DUMP_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  input  logic                  ld_sel,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  input  logic                  go,
  output logic                  done,
  output logic                  timeout,
  output logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] im_addr,
  input  logic                  im_rd,
  output logic [DATA_WIDTH-1:0] im_r_data,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic [DATA_WIDTH-1:0] dm_r_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last
);
  localparam logic [CNT_W-1:0]      TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]      DR_LAST   = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DUMP_WORDS - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [ADDR_WIDTH-1:0] im_a, dm_a;
  logic                 im_rd_i, im_wr_i, dm_rd_i, dm_wr_i;
  logic [DATA_WIDTH-1:0] dm_wd, dm_q;

  // Memory port ownership follows the state; go suppresses a same-cycle load.
  always_comb begin
    im_a = '0; im_rd_i = 1'b0; im_wr_i = 1'b0;
    dm_a = '0; dm_rd_i = 1'b0; dm_wr_i = 1'b0; dm_wd = '0;
    case (state)
      LOAD: begin
        im_a    = ld_addr;
        dm_a    = ld_addr;
        im_wr_i = ld_valid & ~go & ~ld_sel;
        dm_wr_i = ld_valid & ~go & ld_sel;
        dm_wd   = ld_data;
      end
      RUN, DRAIN: begin
        im_a    = im_addr;
        im_rd_i = im_rd;
        dm_a    = dm_addr;
        dm_rd_i = dm_rd;
        dm_wr_i = dm_wr;
        dm_wd   = dm_w_data;
      end
      DUMP_RD: begin
        dm_a    = dump_addr;
        dm_rd_i = 1'b1;
      end
      default: ;
    endcase
  end

  ps_sram #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_im (
    .clk(clk), .rst(rst), .addr(im_a), .rd(im_rd_i), .wr(im_wr_i),
    .w_data(ld_data), .r_data(im_r_data)
  );

  ps_sram #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_dm (
    .clk(clk), .rst(rst), .addr(dm_a), .rd(dm_rd_i), .wr(dm_wr_i),
    .w_data(dm_wd), .r_data(dm_q)
  );

  assign ld_ready  = (state == LOAD);
  assign dm_r_data = dm_q;
  assign dump_data = dump_valid ? dm_q : '0;

  // dump_addr doubles as the dump pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      start      <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      dump_addr  <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        LOAD: if (go) begin
          state <= START;
          start <= 1'b1;
        end
        START: begin
          start <= 1'b0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (stop) begin
            state <= DRAIN;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= DRAIN;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == DR_LAST) begin
            state     <= DUMP_RD;
            dump_addr <= '0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DUMP_RD: begin
          state      <= DUMP_OUT;
          dump_valid <= 1'b1;
          dump_last  <= (dump_addr == LAST_ADDR);
        end
        DUMP_OUT: if (dump_ready) begin
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
          if (dump_last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            dump_addr <= dump_addr + 1'b1;
            state     <= DUMP_RD;
          end
        end
        DONE: if (go) begin
          state   <= LOAD;
          done    <= 1'b0;
          timeout <= 1'b0;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: doc/ps_mem_host.md
PS_MEM_HOST -- requirements
Module: ps_mem_host

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, word address width of both memories.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, cycles waited after stop before dump.
REQ-004 SHALL have parameter TIMEOUT, default 4096, maximum RUN cycles before forced dump.
REQ-005 SHALL have parameter DUMP_WORDS, default 256, DM words streamed out (1..2^ADDR_WIDTH).
REQ-006 SHALL have ports: clk in 1, system clock; rst in 1, asynchronous active-high reset.
REQ-007 SHALL have ports: ld_valid in 1, load request; ld_sel in 1, 0=IM 1=DM; ld_addr in ADDR_WIDTH; ld_data in DATA_WIDTH; ld_ready out 1, load accepted.
REQ-008 SHALL have ports: go in 1, run request; done out 1, dump complete; timeout out 1, run ended by watchdog.
REQ-009 SHALL have ports: start out 1, processor start pulse; stop in 1, processor stopped.
REQ-010 SHALL have ports: im_addr in ADDR_WIDTH; im_rd in 1; im_r_data out DATA_WIDTH.
REQ-011 SHALL have ports: dm_addr in ADDR_WIDTH; dm_rd in 1; dm_wr in 1; dm_w_data in DATA_WIDTH; dm_r_data out DATA_WIDTH.
REQ-012 SHALL have ports: dump_valid out 1; dump_ready in 1; dump_addr out ADDR_WIDTH; dump_data out DATA_WIDTH; dump_last out 1.

Function
REQ-013 SHALL implement FSM states LOAD, START, RUN, DRAIN, DUMP_RD, DUMP_OUT, DONE.
REQ-014 LOAD: ld_ready=1; ld_valid&ld_ready writes ld_data to IM or DM at ld_addr that cycle; go moves to START (go wins over same-cycle ld_valid, load not performed).
REQ-015 START: start=1 for exactly one cycle, next state RUN; start=0 in all other states.
REQ-016 RUN: im_rd=1 returns IM[im_addr] on im_r_data the next cycle; im_rd=0 holds im_r_data.
REQ-017 RUN: dm_rd=1 returns DM[dm_addr] on dm_r_data the next cycle; dm_rd=0 holds dm_r_data.
REQ-018 RUN: dm_wr=1 writes dm_w_data to DM[dm_addr] at the clock edge; simultaneous dm_rd same address returns old data.
REQ-019 Processor-side rd/wr SHALL be ignored outside RUN and DRAIN; host loads ignored outside LOAD (ld_ready=0).
REQ-020 RUN: stop=1 moves to DRAIN; 16-bit cycle counter reaching TIMEOUT-1 without stop sets timeout=1 and moves to DRAIN; stop wins if both occur the same cycle (timeout stays 0).
REQ-021 DRAIN: DM writes still honoured; after DRAIN_CYCLES cycles moves to DUMP_RD with dump pointer 0.
REQ-022 DUMP_RD: issues internal DM read at pointer, next state DUMP_OUT.
REQ-023 DUMP_OUT: dump_valid=1, dump_addr=pointer, dump_data=read word, held stable until dump_ready; dump_last=1 when pointer=DUMP_WORDS-1.
REQ-024 On dump_valid&dump_ready: last word goes to DONE, else pointer+1 and DUMP_RD.
REQ-025 DONE: done=1 held; go returns to LOAD clearing done and timeout; memory contents retained.
REQ-026 Pointer and counters SHALL not wrap; DUMP_WORDS=2^ADDR_WIDTH ends at all-ones address.

Reset
REQ-027 rst SHALL asynchronously force state LOAD; start, done, timeout, dump_valid, dump_last=0; im_r_data, dm_r_data, dump_data, dump_addr=0; counters 0.
REQ-028 Memory arrays SHALL not be cleared by rst; reset mid-RUN or mid-DUMP aborts with no further writes.

Structure
REQ-029 Shared package SHALL hold state encoding, default widths, DRAIN_CYCLES and TIMEOUT defaults.
REQ-030 One sub-module ps_sram (single-clock, 1 write port, synchronous read-old-data) SHALL be instantiated twice, IM and DM; DM read/write port muxed between host load, processor, and dump by state.

Verification
REQ-031 Load IM[0..3] program, DM[5]=16'h1234, go -> start high one cycle, im_r_data=IM[0] one cycle after im_rd@addr 0.
REQ-032 RUN dm_wr addr 5 data 16'hBEEF with dm_rd addr 5 same cycle -> dm_r_data=16'h1234 next cycle, 16'hBEEF on following read.
REQ-033 stop asserted -> exactly DRAIN_CYCLES cycles later DUMP_RD; dump of DUMP_WORDS=8 gives addrs 0..7, dump_last only on 7, DM[5]=16'hBEEF.
REQ-034 dump_ready held low 10 cycles on word 3 -> dump_valid, dump_addr, dump_data stable throughout; no word skipped or duplicated.
REQ-035 TIMEOUT=16, stop never asserted -> timeout=1, dump proceeds, done=1; stop in cycle 15 -> timeout=0.
REQ-036 rst asserted mid-DUMP_OUT -> all outputs 0 immediately, state LOAD, DM contents unchanged on re-dump.
